// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - raster position/sync bundle shared by scan source and painters
interface vga_scan_gen_if;
  logic        anim_en;
  logic [10:0] x;
  logic [10:0] y;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;
  logic [10:0] delt;

  modport master (
    input  anim_en,
    output x, y, hsync, vsync, video_on, frame_start, delt
  );

  modport slave (
    output anim_en,
    input  x, y, hsync, vsync, video_on, frame_start, delt
  );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster counters, registered sync/coordinate decode and
// frame-synchronous bouncing horizontal offset
module vga_scan_gen #(
  parameter int H_VIS     = 800,
  parameter int H_FP      = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BP      = 64,
  parameter int V_VIS     = 600,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter int SYNC_POL  = 1,
  parameter int DELT_MAX  = 250,
  parameter int DELT_STEP = 2
) (
  input  logic          clk,
  input  logic          rst,
  vga_scan_gen_if.master vif
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] H_VISW = 11'(H_VIS);
  localparam logic [10:0] V_VISW = 11'(V_VIS);
  localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic        SYNC_ON = (SYNC_POL != 0);
  localparam logic [11:0] D_MAX12  = 12'(DELT_MAX);
  localparam logic [11:0] D_STEP12 = 12'(DELT_STEP);
  localparam logic [10:0] D_MAX11  = 11'(DELT_MAX);
  localparam logic [10:0] D_STEP11 = 11'(DELT_STEP);

  typedef enum logic {UP, DOWN} dir_t;

  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        h_wrap;
  logic        boundary;
  logic        armed;
  dir_t        dir;
  dir_t        dir_nxt;
  logic [10:0] delt_nxt;
  logic [11:0] delt_up;

  assign h_wrap   = (hcnt == H_LAST);
  assign boundary = (hcnt == 11'd0) && (vcnt == 11'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt <= 11'd0;
      vcnt <= 11'd0;
    end else begin
      hcnt <= h_wrap ? 11'd0 : hcnt + 11'd1;
      if (h_wrap)
        vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
    end
  end

  // Every output is decoded from the counters and registered, so all lag them by one cycle together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vif.x           <= 11'd0;
      vif.y           <= 11'd0;
      vif.hsync       <= ~SYNC_ON;
      vif.vsync       <= ~SYNC_ON;
      vif.video_on    <= 1'b0;
      vif.frame_start <= 1'b0;
    end else begin
      vif.x           <= hcnt;
      vif.y           <= vcnt;
      vif.hsync       <= (hcnt >= HS_BEG && hcnt <= HS_END) ? SYNC_ON : ~SYNC_ON;
      vif.vsync       <= (vcnt >= VS_BEG && vcnt <= VS_END) ? SYNC_ON : ~SYNC_ON;
      vif.video_on    <= (hcnt < H_VISW) && (vcnt < V_VISW);
      vif.frame_start <= boundary;
    end
  end

  // armed stays low through the first boundary after reset so frame 0 always shows delt=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir      <= UP;
      vif.delt <= 11'd0;
      armed    <= 1'b0;
    end else begin
      dir      <= dir_nxt;
      vif.delt <= delt_nxt;
      armed    <= 1'b1;
    end
  end

  assign delt_up = {1'b0, vif.delt} + D_STEP12;

  always_comb begin
    dir_nxt  = dir;
    delt_nxt = vif.delt;
    if (boundary && armed && vif.anim_en) begin
      case (dir)
        UP: begin
          if (delt_up >= D_MAX12) begin
            delt_nxt = D_MAX11;
            dir_nxt  = DOWN;
          end else begin
            delt_nxt = delt_up[10:0];
          end
        end
        DOWN: begin
          if (vif.delt <= D_STEP11) begin
            delt_nxt = 11'd0;
            dir_nxt  = UP;
          end else begin
            delt_nxt = vif.delt - D_STEP11;
          end
        end
        default: begin
          delt_nxt = 11'd0;
          dir_nxt  = UP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - randomized check of two scaled-down scan generators against
// a raster-position reference model
module tb_vga_scan_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   npass = 0;
  int   ntotal = 0;
  int   t = 0;

  int   dmax [2] = '{10, 250};
  int   dstep[2] = '{3, 2};
  int   pol  [2] = '{1, 0};
  int   md   [2];
  bit   mup  [2];

  vga_scan_gen_if vif_a ();
  vga_scan_gen_if vif_b ();

  always #5 clk = ~clk;

  vga_scan_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .DELT_MAX(10), .DELT_STEP(3)
  ) dut_a (.clk(clk), .rst(rst), .vif(vif_a.master));

  vga_scan_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .DELT_MAX(250), .DELT_STEP(2)
  ) dut_b (.clk(clk), .rst(rst), .vif(vif_b.master));

  task automatic check(input string tag, input int got, input int exp);
    ntotal++;
    if (got == exp) npass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0d time=%0t", tag, got, exp, t, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      md[i]  = 0;
      mup[i] = 1'b1;
    end
  endtask

  task automatic model_step(input int i);
    if (mup[i]) begin
      if (md[i] + dstep[i] >= dmax[i]) begin md[i] = dmax[i]; mup[i] = 1'b0; end
      else md[i] = md[i] + dstep[i];
    end else begin
      if (md[i] <= dstep[i]) begin md[i] = 0; mup[i] = 1'b1; end
      else md[i] = md[i] - dstep[i];
    end
  endtask

  task automatic check_reset_state();
    check("rst_x_a", int'(vif_a.x), 0);
    check("rst_y_a", int'(vif_a.y), 0);
    check("rst_von_a", int'(vif_a.video_on), 0);
    check("rst_fs_a", int'(vif_a.frame_start), 0);
    check("rst_delt_a", int'(vif_a.delt), 0);
    check("rst_hs_a", int'(vif_a.hsync), 0);
    check("rst_vs_a", int'(vif_a.vsync), 0);
    check("rst_x_b", int'(vif_b.x), 0);
    check("rst_delt_b", int'(vif_b.delt), 0);
    check("rst_hs_b", int'(vif_b.hsync), 1);
    check("rst_vs_b", int'(vif_b.vsync), 1);
  endtask

  task automatic check_all();
    int ex, ey, ehs, evs, evon, efs;
    ex = t % HT;
    ey = (t / HT) % VT;
    if (t > 0 && (t % FRAME) == 0) begin
      if (vif_a.anim_en) model_step(0);
      if (vif_b.anim_en) model_step(1);
    end
    ehs  = (ex >= HV + HF && ex < HV + HF + HS) ? 1 : 0;
    evs  = (ey >= VV + VF && ey < VV + VF + VS) ? 1 : 0;
    evon = (ex < HV && ey < VV) ? 1 : 0;
    efs  = (ex == 0 && ey == 0) ? 1 : 0;
    check("x_a", int'(vif_a.x), ex);
    check("y_a", int'(vif_a.y), ey);
    check("hsync_a", int'(vif_a.hsync), pol[0] != 0 ? ehs : 1 - ehs);
    check("vsync_a", int'(vif_a.vsync), pol[0] != 0 ? evs : 1 - evs);
    check("video_on_a", int'(vif_a.video_on), evon);
    check("frame_start_a", int'(vif_a.frame_start), efs);
    check("delt_a", int'(vif_a.delt), md[0]);
    check("x_b", int'(vif_b.x), ex);
    check("y_b", int'(vif_b.y), ey);
    check("hsync_b", int'(vif_b.hsync), pol[1] != 0 ? ehs : 1 - ehs);
    check("vsync_b", int'(vif_b.vsync), pol[1] != 0 ? evs : 1 - evs);
    check("video_on_b", int'(vif_b.video_on), evon);
    check("frame_start_b", int'(vif_b.frame_start), efs);
    check("delt_b", int'(vif_b.delt), md[1]);
  endtask

  // anim_en only changes mid-frame, mostly enabled so both bounce limits are reached.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_all();
      if ((t % FRAME) == FRAME / 2) begin
        vif_a.anim_en = ($urandom_range(0, 9) != 0);
        vif_b.anim_en = ($urandom_range(0, 9) != 0);
      end
      t++;
    end
  endtask

  initial begin
    vif_a.anim_en = 1'b1;
    vif_b.anim_en = 1'b1;
    model_reset();
    #12;
    check_reset_state();
    @(negedge clk);
    rst = 1'b1;
    t = 0;
    run_cycles(160 * FRAME);

    run_cycles(FRAME / 2 + 3);
    #3;
    rst = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    check_reset_state();
    rst = 1'b1;
    t = 0;
    model_reset();
    run_cycles(30 * FRAME);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster scan source for the VGA display path: generates 800x600@72 Hz timing (50 MHz pixel clock), the current pixel coordinate (x, y) and a frame-synchronous horizontal offset (delt).
- Its outputs feed the logo/rectangle hit painters, which test x, y against shapes shifted by delt, and drive the VGA connector sync pins.
- It is the producing end of the x/y/delt interface that the painters consume.

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BP, 64, horizontal back porch (pixels); line total 1040
- V_VIS, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines); frame total 666
- SYNC_POL, 1, sync active level (1 = active-high)
- DELT_MAX, 250, upper bound of delt
- DELT_STEP, 2, delt change per frame

Ports:
- clk  in  1  pixel clock, 50 MHz, rising edge
- rst  in  1  asynchronous, active-low reset
- anim_en  in  1  1 = delt animates at frame boundaries; 0 = delt holds
- x  out  11  current column, 0..1039
- y  out  11  current line, 0..665
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  1 when x<800 and y<600
- frame_start  out  1  one-cycle pulse at x=0, y=0
- delt  out  11  horizontal offset for the painters, 0..DELT_MAX

Behaviour:
- The design has one clock. Reset is asynchronous and active-low.
- Reset (rst=0), held regardless of clk:
  - internal hcnt=0, vcnt=0, delt=0, dir=up
  - x=0, y=0, video_on=0, frame_start=0, delt=0
  - hsync=vsync=~SYNC_POL (inactive)
- Counters:
  - hcnt increments each clk and wraps at 1039 to 0.
  - On that wrap, vcnt increments and wraps at 665 to 0.
  - All other cycles hold vcnt.
- Output registration: every output is a register loaded from the current hcnt/vcnt, so all outputs lag the counters by exactly 1 cycle and are mutually aligned. x equals hcnt delayed by 1 cycle; y equals vcnt delayed by 1 cycle.
- Output decode (same cycle as the x/y they accompany):
  - hsync active when 856 <= x <= 975.
  - vsync active when 637 <= y <= 642.
  - video_on = (x<800) && (y<600).
  - frame_start = (x==0) && (y==0).
- First cycle after reset release: outputs show x=0, y=0, frame_start=1.
- delt state machine, two states UP and DOWN, evaluated only on the cycle whose counters are hcnt=0, vcnt=0 (so delt changes together with frame_start=1 and is stable for the whole frame):
  - anim_en=0: delt and dir hold.
  - UP: if delt+DELT_STEP >= DELT_MAX, then delt=DELT_MAX and go to DOWN; else delt += DELT_STEP.
  - DOWN: if delt <= DELT_STEP, then delt=0 and go to UP; else delt -= DELT_STEP.
  - Arithmetic is 11-bit unsigned; the clamping above ensures delt never underflows or exceeds DELT_MAX.
  - anim_en is sampled only at the frame boundary; toggling it mid-frame has no effect until the next boundary.
  - Exception to the above: the very first frame boundary after reset release does not update delt, which stays 0.
- Reset mid-frame: all state returns immediately to reset values. Timing restarts from x=0, y=0 on release.

Test Plan:
- Reset release, run 1040 cycles: x counts 0..1039 then returns to 0; y steps from 0 to 1 exactly when x wraps. frame_start=1 only in the first output cycle.
- One full line, sample the outputs: hsync=1 for exactly 120 cycles, for x=856..975; video_on=1 for x=0..799 on line 0; video_on=0 on every cycle of line 600.
- Full frame of 692,640 cycles: vsync=1 exactly for y=637..642, i.e. 6x1040 cycles. frame_start occurs once per frame, period 692,640.
- anim_en=1, 130 frames: delt reads 0 for frame 0, then 2, 4, ... up to 250 at frame 125, then 248, 246, ...; delt never exceeds 250 and changes only when frame_start=1.
- Bounce at 0: with DELT_STEP=3 and DELT_MAX=10, delt goes 0,3,6,9,10,7,4,1,0,3. Toggle anim_en=0 at mid-frame 4: delt stays 10 until anim_en=1 is seen at a frame boundary.
- Assert rst=0 asynchronously at x=500, y=300 with delt=40: all outputs return to reset values without a clk edge. After release, x=0, y=0, delt=0, frame_start=1.
